// File: rtl/aukv_pkg.sv
// Shared constants and types for the writeback slice: widths, load funct3
// encodings and the layout of a buffered load response.
package aukv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Raw load response as captured at the handshake; formatting happens at pop.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        offset;
    logic [XLEN-1:0]   data;
  } load_entry_t;

endpackage

// File: rtl/aukv_load_align.sv
// Load data formatter: selects the byte/half addressed by the offset and
// sign- or zero-extends it. Unknown funct3 codes fall back to a full word.
module aukv_load_align
  import aukv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] raw_data,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; halfword loads only look at offset[1].
  always_comb begin
    byte_sel = raw_data[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? raw_data[31:16] : raw_data[15:0];
  end

  // Extension by load type.
  always_comb begin
    case (funct3)
      F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ext_data = {24'h0, byte_sel};
      F3_LHU:  ext_data = {16'h0, half_sel};
      default: ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/aukv_writeback.sv
// Writeback stage: merges single-cycle ALU results with buffered load
// responses onto the one register-file write port. The ALU has priority,
// except when a buffered load has been passed over too many times, in which
// case the ALU is stalled for one cycle so the load can drain.
module aukv_writeback
  import aukv_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2   // buffer logic is built for exactly 2 entries
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alu_valid,
  input  logic [REG_AW-1:0] i_alu_rd,
  input  logic [XLEN-1:0]   i_alu_data,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [REG_AW-1:0] i_lsu_rd,
  input  logic [2:0]        i_lsu_funct3,
  input  logic [1:0]        i_lsu_offset,
  input  logic [XLEN-1:0]   i_lsu_data,
  output logic              o_alu_stall,
  output logic              o_we,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_data,
  output logic [XLEN-1:0]   o_busy_mask
);

  localparam int         SC_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  load_entry_t       fifo_mem [FIFO_DEPTH];
  logic [1:0]        count_reg, count_next;
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [SC_W-1:0]   starve_reg, starve_next;
  logic              stall_reg, stall_next;
  logic              we_reg, we_next;
  logic [REG_AW-1:0] rd_reg, rd_next;
  logic [XLEN-1:0]   data_reg, data_next;

  logic              fifo_empty, push, pop, alu_win;
  load_entry_t       head;
  logic [XLEN-1:0]   head_ext;
  logic [XLEN-1:0]   entry_mask [FIFO_DEPTH];

  // Ready depends only on occupancy, so a full buffer never accepts even if it pops.
  always_comb begin
    fifo_empty  = (count_reg == 2'd0);
    o_lsu_ready = (count_reg < FULL_CNT);
    push        = i_lsu_valid && o_lsu_ready;
    alu_win     = i_alu_valid && !stall_reg;
    pop         = !fifo_empty && (stall_reg || !i_alu_valid);
    head        = fifo_mem[rd_ptr_reg];
    count_next  = count_reg + {1'b0, push} - {1'b0, pop};
  end

  aukv_load_align u_align (
    .funct3   (head.funct3),
    .offset   (head.offset),
    .raw_data (head.data),
    .ext_data (head_ext)
  );

  // Starvation tracking: count ALU wins over a waiting load, stall once at the limit.
  always_comb begin
    starve_next = '0;
    stall_next  = 1'b0;
    if (alu_win && !fifo_empty) begin
      if (starve_reg == SC_W'(STARVE_LIMIT - 1)) begin
        stall_next = 1'b1;
      end else begin
        starve_next = starve_reg + 1'b1;
      end
    end
  end

  // Write-port selection; writes to x0 are suppressed.
  always_comb begin
    we_next   = 1'b0;
    rd_next   = rd_reg;
    data_next = data_reg;
    if (alu_win) begin
      we_next   = (i_alu_rd != '0);
      rd_next   = i_alu_rd;
      data_next = i_alu_data;
    end else if (pop) begin
      we_next   = (head.rd != '0);
      rd_next   = head.rd;
      data_next = head_ext;
    end
  end

  // Per-entry busy bits; an entry stays visible until the edge that pops it.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_busy
    always_comb begin
      entry_mask[gi] = '0;
      if ((count_reg == FULL_CNT) || ((count_reg == 2'd1) && (rd_ptr_reg == 1'(gi))))
        entry_mask[gi] = XLEN'(1) << fifo_mem[gi].rd;
    end
  end

  // Merge entry bits; x0 is never reported busy.
  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) o_busy_mask = o_busy_mask | entry_mask[i];
    o_busy_mask[0] = 1'b0;
  end

  // Buffer storage holds raw response fields; no reset needed, count gates validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{rd: i_lsu_rd, funct3: i_lsu_funct3,
                                offset: i_lsu_offset, data: i_lsu_data};
    end
  end

  // Control state and registered write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      starve_reg <= '0;
      stall_reg  <= 1'b0;
      we_reg     <= 1'b0;
      rd_reg     <= '0;
      data_reg   <= '0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_reg ^ push;
      rd_ptr_reg <= rd_ptr_reg ^ pop;
      starve_reg <= starve_next;
      stall_reg  <= stall_next;
      we_reg     <= we_next;
      rd_reg     <= rd_next;
      data_reg   <= data_next;
    end
  end

  assign o_alu_stall = stall_reg;
  assign o_we        = we_reg;
  assign o_rd_addr   = rd_reg;
  assign o_data      = data_reg;

endmodule

// File: tb/tb_aukv_writeback.sv
// Bench for aukv_writeback: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_aukv_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [2:0]  lsu_f3;
  logic [1:0]  lsu_off;
  logic [31:0] lsu_data;
  logic        alu_stall;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] wdata;
  logic [31:0] busy_mask;

  int checks   = 0;
  int failures = 0;

  aukv_writeback #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_valid  (alu_valid),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_lsu_valid  (lsu_valid),
    .o_lsu_ready  (lsu_ready),
    .i_lsu_rd     (lsu_rd),
    .i_lsu_funct3 (lsu_f3),
    .i_lsu_offset (lsu_off),
    .i_lsu_data   (lsu_data),
    .o_alu_stall  (alu_stall),
    .o_we         (we),
    .o_rd_addr    (rd_addr),
    .o_data       (wdata),
    .o_busy_mask  (busy_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] data;
  } ld_t;

  ld_t         q[$];
  int          m_starve;
  bit          m_stall;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic logic [31:0] fmt(ld_t e);
    logic [31:0] b, h;
    b = (e.data >> (8 * e.off)) & 32'hFF;
    h = (e.data >> (e.off[1] ? 16 : 0)) & 32'hFFFF;
    case (e.f3)
      3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return e.data;
    endcase
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = 32'h0;
    foreach (q[i]) if (q[i].rd != 5'd0) m = m | (32'h1 << q[i].rd);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one edge with the current inputs, clock the DUT, compare.
  task automatic tick();
    bit   ready_b;
    bit   do_pop;
    ld_t  e;
    ready_b = (q.size() < 2);
    if (!rst) chk("proto_alu_during_stall", {31'b0, alu_valid && alu_stall}, 32'h0);
    if (rst) begin
      q.delete();
      m_starve = 0; m_stall = 0; m_we = 0; m_rd = 5'd0; m_data = 32'h0;
    end else begin
      do_pop = 0;
      m_we   = 0;
      if (!m_stall && alu_valid) begin
        m_we = (alu_rd != 5'd0); m_rd = alu_rd; m_data = alu_data;
        if (q.size() > 0) m_starve++;
        else m_starve = 0;
      end else begin
        m_starve = 0;
        if (q.size() > 0) begin
          do_pop = 1;
          m_we = (q[0].rd != 5'd0); m_rd = q[0].rd; m_data = fmt(q[0]);
        end
      end
      m_stall = (m_starve == 4);
      if (m_stall) m_starve = 0;
      if (do_pop) void'(q.pop_front());
      if (lsu_valid && ready_b) begin
        e.rd = lsu_rd; e.f3 = lsu_f3; e.off = lsu_off; e.data = lsu_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("we", {31'b0, we}, {31'b0, m_we});
    if (m_we) begin
      chk("rd_addr", {27'b0, rd_addr}, {27'b0, m_rd});
      chk("data", wdata, m_data);
    end
    chk("alu_stall", {31'b0, alu_stall}, {31'b0, m_stall});
    chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, q.size() < 2});
    chk("busy_mask", busy_mask, model_mask());
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                       input logic [1:0] loff, input logic [31:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_f3 = lf3; lsu_off = loff; lsu_data = ld;
    tick();
  endtask

  task automatic idle();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 3'd0, 2'd0, 32'h0);
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    m_starve = 0; m_stall = 0; m_we = 0; m_rd = 5'd0; m_data = 32'h0;
    rst = 1'b1;
    idle();
    // Reset state
    chk("rst_we", {31'b0, we}, 32'h0);
    chk("rst_rd", {27'b0, rd_addr}, 32'h0);
    chk("rst_data", wdata, 32'h0);
    chk("rst_ready", {31'b0, lsu_ready}, 32'h1);
    rst = 1'b0;
    idle();

    // 1. ALU write
    drive(1, 5'd5, 32'h1234_5678, 0, 5'd0, 3'd0, 2'd0, 32'h0);
    chk("t1_we", {31'b0, we}, 32'h1);
    chk("t1_rd", {27'b0, rd_addr}, 32'd5);
    chk("t1_data", wdata, 32'h1234_5678);
    idle();
    chk("t1_we_off", {31'b0, we}, 32'h0);

    // 2. x0 suppression for both sources
    drive(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 3'b010, 2'd0, 32'hDEAD_BEEF);
    chk("t2_we_alu", {31'b0, we}, 32'h0);
    idle();
    chk("t2_we_load", {31'b0, we}, 32'h0);
    chk("t2_ready", {31'b0, lsu_ready}, 32'h1);
    idle();

    // 3. Load formatting
    drive(0, 5'd0, 32'h0, 1, 5'd7, 3'b000, 2'd3, 32'h80AA_BBCC); idle();
    chk("t3_lb", wdata, 32'hFFFF_FF80);
    drive(0, 5'd0, 32'h0, 1, 5'd7, 3'b100, 2'd3, 32'h80AA_BBCC); idle();
    chk("t3_lbu", wdata, 32'h0000_0080);
    drive(0, 5'd0, 32'h0, 1, 5'd7, 3'b101, 2'd2, 32'h80AA_BBCC); idle();
    chk("t3_lhu", wdata, 32'h0000_80AA);
    drive(0, 5'd0, 32'h0, 1, 5'd7, 3'b001, 2'd0, 32'h80AA_BBCC); idle();
    chk("t3_lh", wdata, 32'hFFFF_BBCC);

    // 4. Starvation: two loads buffered behind a continuously valid ALU
    drive(1, 5'd10, 32'hA0, 1, 5'd3, 3'b010, 2'd0, 32'h3333_3333);
    drive(1, 5'd11, 32'hA1, 1, 5'd4, 3'b010, 2'd0, 32'h4444_4444);
    chk("t4_ready_full", {31'b0, lsu_ready}, 32'h0);
    chk("t4_mask", busy_mask, 32'h18);
    drive(1, 5'd12, 32'hA2, 0, 5'd0, 3'd0, 2'd0, 32'h0);
    drive(1, 5'd13, 32'hA3, 0, 5'd0, 3'd0, 2'd0, 32'h0);
    drive(1, 5'd14, 32'hA4, 0, 5'd0, 3'd0, 2'd0, 32'h0);
    chk("t4_stall", {31'b0, alu_stall}, 32'h1);
    idle();
    chk("t4_rd3", {27'b0, rd_addr}, 32'd3);
    chk("t4_data3", wdata, 32'h3333_3333);
    chk("t4_mask_after", busy_mask, 32'h10);
    chk("t4_stall_one", {31'b0, alu_stall}, 32'h0);
    idle(); idle();

    // 5. Load latency and back-to-back ordering
    drive(0, 5'd0, 32'h0, 1, 5'd9, 3'b010, 2'd0, 32'h9999_0000);
    chk("t5_no_early", {31'b0, we}, 32'h0);
    drive(0, 5'd0, 32'h0, 1, 5'd11, 3'b100, 2'd1, 32'h0000_5A00);
    chk("t5_first_rd", {27'b0, rd_addr}, 32'd9);
    chk("t5_first_we", {31'b0, we}, 32'h1);
    idle();
    chk("t5_second_rd", {27'b0, rd_addr}, 32'd11);
    chk("t5_second_data", wdata, 32'h5A);
    idle();

    // 6. Reset with buffered loads and a stall pending
    drive(1, 5'd20, 32'h1, 1, 5'd21, 3'b010, 2'd0, 32'h21);
    drive(1, 5'd20, 32'h2, 1, 5'd22, 3'b010, 2'd0, 32'h22);
    drive(1, 5'd20, 32'h3, 0, 5'd0, 3'd0, 2'd0, 32'h0);
    drive(1, 5'd20, 32'h4, 0, 5'd0, 3'd0, 2'd0, 32'h0);
    alu_valid = 0;
    rst = 1'b1;
    tick();
    chk("t6_we", {31'b0, we}, 32'h0);
    chk("t6_mask", busy_mask, 32'h0);
    chk("t6_stall", {31'b0, alu_stall}, 32'h0);
    chk("t6_ready", {31'b0, lsu_ready}, 32'h1);
    rst = 1'b0;
    idle();
    chk("t6_no_write", {31'b0, we}, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(m_stall ? 1'b0 : ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
            f3_tab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), $urandom);
    end
    rst = 1'b0;
    idle(); idle(); idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aukv_writeback.md
Name: aukv_writeback

Overview:
Writeback stage that drives the single write port of the GPR register file. It merges two result sources: single-cycle ALU results and load responses from the LSU. Load responses arrive with a valid/ready handshake and are held in a 2-entry buffer. Loads are sign- or zero-extended per funct3 and byte offset before they are written. The block sits between the EX/LSU stages and the register file, and exports a pending-write mask for hazard detection.

Parameters:
STARVE_LIMIT, 4, number of consecutive cycles a buffered load may be pre-empted by the ALU before the block forces a stall.
FIFO_DEPTH, 2, load-response buffer depth; fixed at 2, and the parameter exists for documentation only.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_alu_valid  in  1  ALU result valid this cycle; the ALU does not accept backpressure except through o_alu_stall
i_alu_rd  in  5  ALU destination register
i_alu_data  in  32  ALU result
i_lsu_valid  in  1  load response valid
o_lsu_ready  out  1  load response accepted when valid&&ready
i_lsu_rd  in  5  load destination register
i_lsu_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
i_lsu_offset  in  2  byte address bits [1:0]
i_lsu_data  in  32  raw aligned memory word
o_alu_stall  out  1  upstream must hold i_alu_valid low next cycle
o_we  out  1  register file write enable
o_rd_addr  out  5  register file write address
o_data  out  32  register file write data
o_busy_mask  out  32  bit n set when a buffered load targets xn; bit 0 always 0

Behaviour:
- Reset is synchronous and active-high, on i_rst sampled at the rising edge of i_clk. It clears o_we, o_rd_addr, o_data, the FIFO count and pointers, the starvation counter and o_alu_stall. o_lsu_ready is 1 after reset.
- All regfile outputs are registered, with one write per cycle.
- ALU latency: i_alu_valid sampled at edge k gives o_we=1 with i_alu_rd/i_alu_data after edge k.
- Load path: a handshake at edge k pushes an entry into the FIFO. The entry is eligible from the cycle after edge k, so the earliest o_we is after edge k+1.
- o_lsu_ready = (count < 2). It is not a function of the same-cycle pop, so there is no pop-through when full.
- Arbitration each cycle, in priority order:
  1. If o_alu_stall=1, pop the FIFO head.
  2. Else if i_alu_valid, the ALU wins.
  3. Else if the FIFO is non-empty, pop the head.
  4. Else o_we=0.
- If i_alu_valid arrives while o_alu_stall=1, it is a protocol error: the ALU result is dropped and the FIFO pops. Verification asserts this never occurs.
- x0 suppression: a winning source with rd=0 produces o_we=0. An rd=0 load is still popped, and o_rd_addr/o_data are don't-care. o_we is never 1 with o_rd_addr=0.
- Starvation counter:
  - Increments on each cycle the ALU wins while the FIFO is non-empty.
  - Clears on any pop or when the FIFO is empty.
  - When it reaches STARVE_LIMIT, o_alu_stall is registered high for exactly one cycle and the counter clears.
- Load formatting, applied at pop time on stored raw fields:
  - LB/LBU select byte i_lsu_offset.
  - LH/LHU select half offset[1]; offset[0] is ignored.
  - LW passes the word through.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Undefined funct3 values are treated as LW.
- o_busy_mask is combinational from the valid FIFO entries. An entry popped this cycle remains in the mask until the edge.
- Simultaneous push and pop with count=1: count stays 1 and the pointers advance.
- Reset mid-operation discards buffered loads with no write.

Decomposition:
- Package aukv_pkg: funct3 load constants (LB/LH/LW/LBU/LHU), register address width 5, XLEN 32.
- Sub-module aukv_load_align: combinational, with inputs funct3, offset and raw data, and output the extended 32-bit value. It is reused by the LSU for future misaligned support.

Test Plan:
1. ALU valid, rd=5, data=0x1234_5678 -> after the next edge o_we=1, o_rd_addr=5, o_data=0x1234_5678; the following cycle o_we=0.
2. ALU rd=0, data=0xFFFF_FFFF, and a load with rd=0 -> o_we stays 0 throughout; the load is still consumed and o_lsu_ready returns to 1.
3. Load LB, offset=3, raw=0x80AA_BBCC, rd=7 -> o_data=0xFFFF_FF80. Also:
   - LBU same word -> 0x0000_0080.
   - LHU offset=2 -> 0x0000_80AA.
   - LH offset=0 -> 0xFFFF_BBCC.
4. Push two loads (rd=3, rd=4) while ALU is valid every cycle -> o_lsu_ready=0 once count=2, and o_busy_mask=0x18. After 4 ALU wins, o_alu_stall=1 for one cycle; the next write is rd=3, and the mask becomes 0x10.
5. Load push at edge k with no ALU activity -> o_we=1 after edge k+1. A back-to-back second load is written the next cycle, in order.
6. Assert i_rst with 2 buffered loads and o_alu_stall pending -> after the edge, o_we=0, o_busy_mask=0, o_alu_stall=0, o_lsu_ready=1, and no write occurs.
